// File: rtl/median_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : median_sched_if
//  Description : Bundle of the sample, median-unit and result signals used by
//                median_sched.
//                slave  - the scheduler (median_sched)
//                master - the surroundings: sample sources, the external
//                         combinational median unit and the result sink
//  Signals     : in_valid_x/in_data_x/in_ready_x  per-channel sample handshake
//                med_vec/med_out                   median unit operands/result
//                out_valid/out_data/out_ch/out_ready  result handshake
//  Revision    : 1.0  initial release
// ============================================================================
interface median_sched_if #(
    parameter int DATA_W = 6,
    parameter int FRAME  = 5
);
    logic                       in_valid_a;
    logic [DATA_W-1:0]          in_data_a;
    logic                       in_ready_a;
    logic                       in_valid_b;
    logic [DATA_W-1:0]          in_data_b;
    logic                       in_ready_b;
    logic [DATA_W*FRAME-1:0]    med_vec;
    logic [DATA_W-1:0]          med_out;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic                       out_ch;
    logic                       out_ready;

    modport master (
        output in_valid_a, in_data_a, in_valid_b, in_data_b,
        input  in_ready_a, in_ready_b,
        input  med_vec,
        output med_out,
        input  out_valid, out_data, out_ch,
        output out_ready
    );

    modport slave (
        input  in_valid_a, in_data_a, in_valid_b, in_data_b,
        output in_ready_a, in_ready_b,
        output med_vec,
        input  med_out,
        output out_valid, out_data, out_ch,
        input  out_ready
    );
endinterface
`default_nettype wire

// File: rtl/median_sched.sv
`default_nettype none
// ============================================================================
//  Module      : median_sched
//  Description : Round-robin scheduler sharing one external combinational
//                5-input median unit between two sample streams (A=0, B=1).
//                Each channel collects a 5-sample frame; a full frame requests
//                the median unit, the granted frame is driven on med_vec and
//                the unit's answer is registered onto a valid/ready output.
//  Ports       : clk        rising-edge clock
//                rst        asynchronous active-high reset
//                bus        median_sched_if.slave (sample inputs, median unit
//                           operand/result, result output handshake)
//  Revision    : 1.0  initial release
// ============================================================================
module median_sched #(
    parameter int DATA_W = 6,
    parameter int FRAME  = 5
) (
    input  logic            clk,
    input  logic            rst,
    median_sched_if.slave   bus
);

    // Collector FSM encoding
    localparam logic [0:0] c_ST_COLLECT = 1'b0;
    localparam logic [0:0] c_ST_FULL    = 1'b1;

    localparam logic [2:0] c_CNT_FULL   = 3'(FRAME);
    localparam logic [2:0] c_CNT_LAST   = 3'(FRAME - 1);

    // ------------------------------------------------------------------
    // Channel-indexed views of the two input streams
    // ------------------------------------------------------------------
    logic [1:0]         w_in_valid;
    logic [DATA_W-1:0]  w_in_data [2];

    assign w_in_valid   = {bus.in_valid_b, bus.in_valid_a};
    assign w_in_data[0] = bus.in_data_a;
    assign w_in_data[1] = bus.in_data_b;

    // ------------------------------------------------------------------
    // Collector state
    // ------------------------------------------------------------------
    logic [2:0]         r_cnt   [2];
    logic [0:0]         r_state [2];
    logic [DATA_W-1:0]  r_slot  [2][FRAME];

    logic [1:0]         w_ready;
    logic [1:0]         w_acc;
    logic [1:0]         w_req;
    logic [1:0]         w_gnt;

    // ------------------------------------------------------------------
    // Output stage state
    // ------------------------------------------------------------------
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_ch;
    logic               r_last_grant;

    logic               w_free;
    logic               w_sel;

    // ------------------------------------------------------------------
    // Per-channel handshake and request
    // ------------------------------------------------------------------
    generate
        for (genvar c = 0; c < 2; c++) begin : g_ch
            assign w_ready[c] = (r_cnt[c] != c_CNT_FULL);
            assign w_acc[c]   = w_in_valid[c] & w_ready[c];
            assign w_req[c]   = (r_state[c] == c_ST_FULL);
        end
    endgenerate

    assign bus.in_ready_a = w_ready[0];
    assign bus.in_ready_b = w_ready[1];

    // ------------------------------------------------------------------
    // Arbitration. The result slot is free when empty or being drained
    // this cycle, which lets a new result load back-to-back. On a
    // contest the channel that did not win last time is preferred.
    // ------------------------------------------------------------------
    assign w_free   = !r_out_valid | bus.out_ready;
    assign w_gnt[0] = w_free & w_req[0] & (!w_req[1] |  r_last_grant);
    assign w_gnt[1] = w_free & w_req[1] & (!w_req[0] | !r_last_grant);

    // Operand mux: channel B only when B is granted, otherwise channel A
    assign w_sel = w_gnt[1];

    generate
        for (genvar i = 0; i < FRAME; i++) begin : g_med_op
            assign bus.med_vec[i*DATA_W +: DATA_W] = r_slot[w_sel][i];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Collector count and FSM. Grants happen only in FULL and accepts
    // only in COLLECT (in_ready is low while the count sits at FRAME),
    // so the two branches never compete within a channel.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                r_cnt[c]   <= 3'd0;
                r_state[c] <= c_ST_COLLECT;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                case (r_state[c])
                    c_ST_COLLECT: begin
                        if (w_acc[c]) begin
                            r_cnt[c] <= r_cnt[c] + 3'd1;
                            if (r_cnt[c] == c_CNT_LAST) begin
                                r_state[c] <= c_ST_FULL;
                            end
                        end
                    end
                    c_ST_FULL: begin
                        if (w_gnt[c]) begin
                            r_cnt[c]   <= 3'd0;
                            r_state[c] <= c_ST_COLLECT;
                        end
                    end
                    default: begin
                        r_cnt[c]   <= 3'd0;
                        r_state[c] <= c_ST_COLLECT;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample storage. Slots need no reset: a frame is only consumed once
    // all of its slots have been written since the count was cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < FRAME; s++) begin
                if (w_acc[c] && (r_cnt[c] == 3'(s))) begin
                    r_slot[c][s] <= w_in_data[c];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Result register. last_grant resets to B so that A wins the first
    // contest.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ch     <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_gnt[0] | w_gnt[1]) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= bus.med_out;
                r_out_ch     <= w_gnt[1];
                r_last_grant <= w_gnt[1];
            end else if (r_out_valid & bus.out_ready) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_median_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_median_sched
//  Description : Directed self-checking bench for median_sched. Hosts a
//                behavioural 5-input median unit on med_vec/med_out.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_median_sched;

    localparam int NF = 500;   // random-phase frames per channel

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    median_sched_if #(.DATA_W(6), .FRAME(5)) bus ();

    median_sched #(.DATA_W(6), .FRAME(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // External median unit
    function automatic logic [5:0] median5(input logic [29:0] v);
        logic [5:0] a [5];
        logic [5:0] t;
        for (int i = 0; i < 5; i++) a[i] = v[i*6 +: 6];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[2];
    endfunction

    always_comb bus.med_out = median5(bus.med_vec);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frames are packed {op4,op3,op2,op1,op0}; op0 is sent first
    task automatic feed(input logic ea, input logic [29:0] fa,
                        input logic eb, input logic [29:0] fb);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid_a = ea;
            bus.in_data_a  = fa[i*6 +: 6];
            bus.in_valid_b = eb;
            bus.in_data_b  = fb[i*6 +: 6];
            tick();
        end
        bus.in_valid_a = 1'b0;
        bus.in_valid_b = 1'b0;
    endtask

    logic [29:0] fa, fb;
    logic [29:0] cur_a, cur_b;
    logic [5:0]  q_a [$];
    logic [5:0]  q_b [$];
    logic [5:0]  da, db, expd;
    logic        va, vb, acc_a, acc_b;
    int          sent_a, sent_b, got, cyc;

    initial begin
        rst = 1'b1;
        bus.in_valid_a = 1'b0; bus.in_data_a = '0;
        bus.in_valid_b = 1'b0; bus.in_data_b = '0;
        bus.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // ---------------- reset values ----------------
        chk("rst_ready_a", bus.in_ready_a, 1);
        chk("rst_ready_b", bus.in_ready_b, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_ch", bus.out_ch, 0);
        rst = 1'b0;
        tick();

        // ---------------- single A frame 3,9,1,7,5 ----------------
        fa = {6'd5, 6'd7, 6'd1, 6'd9, 6'd3};
        feed(1'b1, fa, 1'b0, '0);
        chk("t1_med_vec", bus.med_vec, {6'd5, 6'd7, 6'd1, 6'd9, 6'd3});
        chk("t1_ready_low", bus.in_ready_a, 0);
        chk("t1_valid_not_yet", bus.out_valid, 0);
        tick();
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_data", bus.out_data, 5);
        chk("t1_ch", bus.out_ch, 0);
        chk("t1_ready_back", bus.in_ready_a, 1);
        tick();
        chk("t1_valid_drop", bus.out_valid, 0);

        // ---------------- simultaneous frames after reset ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fa = {6'd50, 6'd40, 6'd30, 6'd20, 6'd10};
        fb = {6'd1, 6'd0, 6'd63, 6'd0, 6'd63};
        feed(1'b1, fa, 1'b1, fb);
        chk("t2_vec_a_first", bus.med_vec, fa);
        chk("t2_ready_b_low", bus.in_ready_b, 0);
        tick();
        chk("t2_a_valid", bus.out_valid, 1);
        chk("t2_a_data", bus.out_data, 30);
        chk("t2_a_ch", bus.out_ch, 0);
        chk("t2_vec_b", bus.med_vec, fb);
        tick();
        chk("t2_b_valid", bus.out_valid, 1);
        chk("t2_b_data", bus.out_data, 1);
        chk("t2_b_ch", bus.out_ch, 1);
        tick();
        chk("t2_valid_drop", bus.out_valid, 0);

        // A-only frame so that A is the last winner
        fa = {6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
        feed(1'b1, fa, 1'b0, '0);
        tick();
        chk("t2c_data", bus.out_data, 3);
        chk("t2c_ch", bus.out_ch, 0);
        tick();

        // ---------------- ties and extremes, contest after A won ----------------
        fa = {6'd63, 6'd0, 6'd0, 6'd63, 6'd63};
        fb = {6'd1, 6'd63, 6'd0, 6'd0, 6'd0};
        feed(1'b1, fa, 1'b1, fb);
        chk("t4_vec_b_first", bus.med_vec, fb);
        tick();
        chk("t4_b_data", bus.out_data, 0);
        chk("t4_b_ch", bus.out_ch, 1);
        tick();
        chk("t4_a_data", bus.out_data, 63);
        chk("t4_a_ch", bus.out_ch, 0);
        chk("t4_a_valid", bus.out_valid, 1);
        tick();
        chk("t4_valid_drop", bus.out_valid, 0);

        // ---------------- backpressure ----------------
        bus.out_ready = 1'b0;
        fa = {6'd15, 6'd14, 6'd13, 6'd12, 6'd11};
        feed(1'b1, fa, 1'b0, '0);
        tick();
        chk("t3_first_data", bus.out_data, 13);
        fa = {6'd24, 6'd23, 6'd22, 6'd21, 6'd20};
        feed(1'b1, fa, 1'b0, '0);
        chk("t3_ready_low", bus.in_ready_a, 0);
        tick();
        chk("t3_hold_valid", bus.out_valid, 1);
        chk("t3_hold_data", bus.out_data, 13);
        chk("t3_hold_ch", bus.out_ch, 0);
        bus.in_valid_a = 1'b1;
        bus.in_data_a  = 6'd7;
        tick();
        chk("t3_offer_ready", bus.in_ready_a, 0);
        chk("t3_offer_data", bus.out_data, 13);
        bus.in_valid_a = 1'b0;
        bus.out_ready  = 1'b1;
        chk("t3_vec", bus.med_vec, fa);
        tick();
        chk("t3_b2b_valid", bus.out_valid, 1);
        chk("t3_b2b_data", bus.out_data, 22);
        chk("t3_ready_back", bus.in_ready_a, 1);
        tick();
        chk("t3_valid_drop", bus.out_valid, 0);

        // ---------------- asynchronous reset mid-frame ----------------
        bus.out_ready = 1'b0;
        fb = {6'd9, 6'd1, 6'd1, 6'd1, 6'd1};
        feed(1'b0, '0, 1'b1, fb);
        tick();
        chk("t5_pending", bus.out_valid, 1);
        chk("t5_pending_ch", bus.out_ch, 1);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid_a = 1'b1;
            bus.in_data_a  = 6'(40 + i);
            tick();
        end
        bus.in_valid_a = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("t5_valid", bus.out_valid, 0);
        chk("t5_data", bus.out_data, 0);
        chk("t5_ch", bus.out_ch, 0);
        chk("t5_ready_a", bus.in_ready_a, 1);
        chk("t5_ready_b", bus.in_ready_b, 1);
        #2 rst = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        fa = {6'd10, 6'd8, 6'd6, 6'd4, 6'd2};
        feed(1'b1, fa, 1'b0, '0);
        chk("t5_vec", bus.med_vec, fa);
        tick();
        chk("t5_result", bus.out_data, 6);
        chk("t5_result_ch", bus.out_ch, 0);
        tick();

        // ---------------- random gaps and backpressure ----------------
        sent_a = 0; sent_b = 0; got = 0; cyc = 0;
        cur_a = '0; cur_b = '0;
        while ((got < 2*NF) && (cyc < 60000)) begin
            va = (sent_a < NF*5) && ($urandom_range(0, 2) != 0);
            vb = (sent_b < NF*5) && ($urandom_range(0, 2) != 0);
            da = 6'($urandom_range(0, 63));
            db = 6'($urandom_range(0, 63));
            bus.in_valid_a = va; bus.in_data_a = da;
            bus.in_valid_b = vb; bus.in_data_b = db;
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            #3;
            acc_a = va && bus.in_ready_a;
            acc_b = vb && bus.in_ready_b;
            if (bus.out_valid && bus.out_ready) begin
                got++;
                if (bus.out_ch == 1'b0) begin
                    chk("rand_a_expected", (q_a.size() > 0), 1);
                    if (q_a.size() > 0) begin
                        expd = q_a.pop_front();
                        chk("rand_a_data", bus.out_data, expd);
                    end
                end else begin
                    chk("rand_b_expected", (q_b.size() > 0), 1);
                    if (q_b.size() > 0) begin
                        expd = q_b.pop_front();
                        chk("rand_b_data", bus.out_data, expd);
                    end
                end
            end
            tick();
            cyc++;
            if (acc_a) begin
                cur_a[(sent_a % 5)*6 +: 6] = da;
                sent_a++;
                if (sent_a % 5 == 0) q_a.push_back(median5(cur_a));
            end
            if (acc_b) begin
                cur_b[(sent_b % 5)*6 +: 6] = db;
                sent_b++;
                if (sent_b % 5 == 0) q_b.push_back(median5(cur_b));
            end
        end
        bus.in_valid_a = 1'b0;
        bus.in_valid_b = 1'b0;
        chk("rand_results", got, 2*NF);
        chk("rand_a_drained", q_a.size(), 0);
        chk("rand_b_drained", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/median_sched.md
Name: median_sched

Overview:
- Round-robin scheduler that shares one external combinational 5-input median unit between two sample streams, A and B.
- Each channel collects 5-sample frames of 6-bit data.
- A full frame requests the median unit. The granted frame is driven onto the unit's operand bus, and the result is registered to a single output with valid/ready handshake.
- Sits between the sample sources and the median datapath. The median unit itself stays purely combinational and outside this block.

Parameters:
- DATA_W, 6, sample and result width (the median unit is 6-bit; other values are unsupported).
- FRAME, 5, samples per frame (fixed by the median unit).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid_a  in  1  channel A sample valid
- in_data_a  in  6  channel A sample
- in_ready_a  out  1  channel A can accept
- in_valid_b  in  1  channel B sample valid
- in_data_b  in  6  channel B sample
- in_ready_b  out  1  channel B can accept
- med_vec  out  30  operands to median unit; operand i on bits [6i+5:6i]
- med_out  in  6  median result from unit (combinational in med_vec)
- out_valid  out  1  result valid
- out_data  out  6  median of granted frame
- out_ch  out  1  source channel of result (0=A, 1=B)
- out_ready  in  1  downstream accepts result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all collectors empty (cnt_a=cnt_b=0), in_ready_a=in_ready_b=1, out_valid=0, out_data=0, out_ch=0, last_grant=1 (so A wins the first contest).
- Per-channel collector:
  - 5 registers and a 3-bit count, 0..5.
  - in_ready_x = (cnt_x != 5).
  - An accept is in_valid_x & in_ready_x. On accept, the sample is stored at slot cnt_x and cnt_x increments.
  - Data on in_data_x is ignored when no accept occurs.
- Per-channel FSM:
  - COLLECT (cnt<5) moves to FULL when the 5th sample is accepted.
  - FULL moves to COLLECT on grant; cnt is cleared at the grant edge.
  - No accept is possible in FULL. A new sample is accepted at the earliest the cycle after the grant.
- Request: req_x = (cnt_x == 5).
- Output slot free: free = !out_valid | out_ready.
- Arbitration, combinational each cycle:
  - If free and exactly one channel requests, grant that channel.
  - If free and both request, grant the channel != last_grant.
  - If not free, grant nothing.
- Grant edge updates:
  - out_data <= med_out
  - out_ch <= granted channel
  - out_valid <= 1
  - last_grant <= granted channel
  - granted collector count <= 0
- med_vec:
  - Carries slots 0..4 of the winning collector in the grant cycle.
  - When there is no grant, it carries channel A's slots.
  - Operand order equals acceptance order.
- Output handshake:
  - A result transfers when out_valid & out_ready.
  - On transfer with no new grant, out_valid <= 0.
  - On transfer with a simultaneous grant, the new result loads back-to-back and out_valid stays 1.
  - While out_valid & !out_ready: out_data and out_ch hold stable, no grant occurs, and FULL channels stay FULL (in_ready low).
- Latency: the 5th sample is accepted at edge E; with a free output, out_valid=1 after edge E+1.
- Throughput: at most one result per cycle. With both channels continuously full, grants alternate A, B, A, ...
- Simultaneous events:
  - Accepts on A and B in the same cycle are independent.
  - An accept on one channel and a grant to the other in the same cycle are independent.
- Reset mid-frame: partial frames and any pending result are discarded immediately; the next frame starts at slot 0.
- Arithmetic: no arithmetic in this block beyond the 3-bit counts; the counts saturate at 5 by construction.

Test Plan:
- A sends 3,9,1,7,5 back-to-back with out_ready=1; B idle -> med_vec={5,7,1,9,3} (op0=3) in the grant cycle; out_valid rises one cycle after the 5th accept; out_data=5, out_ch=0; in_ready_a low for exactly 1 cycle.
- After reset, A and B complete frames on the same edge (A: 10,20,30,40,50; B: 63,0,63,0,1) -> A result 30 first, B result 1 next cycle; the next simultaneous contest grants B first.
- Backpressure: out_ready=0 with a result pending and A full -> out_data/out_ch held stable, in_ready_a=0, A sample offered is not accepted. Raise out_ready -> A's result loads on the same edge the old one transfers, so out_valid stays 1.
- Ties and extremes: A frame 63,63,0,0,63 -> 63; B frame 0,0,0,63,1 -> 0.
- rst pulsed asynchronously mid-cycle after 3 A samples and with out_valid=1 -> outputs return to reset values immediately; a subsequent 5-sample A frame 2,4,6,8,10 yields 6.
- Randomised valid gaps on both channels with random out_ready for 1000 frames -> every frame yields exactly one result, per-channel order is preserved, and no channel waits more than one grant while the other is also requesting.
